// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift register with auto-burst engine
//
// Purpose:
//   Holds a WIDTH-bit word that can be parallel loaded, shifted once on request,
//   or shifted by an automatic burst of cnt back-to-back steps. Supported step
//   modes: logical/arithmetic right, logical left, rotate right/left, hold.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   load_i       parallel load strobe (highest priority, aborts a burst)
//   din_i        parallel load data
//   shift_en_i   single shift step, honoured only while idle
//   mode_i       0 LSR, 1 ASR, 2 LSL, 3 ROR, 4 ROL, 5-7 hold
//   amt_i        bits shifted per step
//   fill_i       bit inserted at vacated positions for LSR/LSL
//   start_i      begin a burst of cnt_i steps, honoured only while idle
//   cnt_i        burst step count
//   dout_o       register contents
//   busy_o       burst in progress
//   done_o       one-cycle pulse coincident with the final burst value
//   parity_o     even parity of dout_o (present only with SHIFT_REG_PARITY_EN)
//
// Build option:
//   SHIFT_REG_PARITY_EN - adds the registered parity_o output.

module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             shift_en_i,
    input  logic [2:0]       mode_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             fill_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    localparam logic [2:0] MODE_LSR = 3'd0;
    localparam logic [2:0] MODE_ASR = 3'd1;
    localparam logic [2:0] MODE_LSL = 3'd2;
    localparam logic [2:0] MODE_ROR = 3'd3;
    localparam logic [2:0] MODE_ROL = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       mode_q;
    logic [AMT_W-1:0] amt_q;
    logic             fill_q;
    logic [WIDTH-1:0] step_live;
    logic [WIDTH-1:0] step_run;
`ifdef SHIFT_REG_PARITY_EN
    logic             parity_q;
`endif

    // One shift step of d by amt under the given mode.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic [AMT_W-1:0] amt,
        input logic             fill
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fills;
        logic [WIDTH-1:0] res;
        int unsigned      a;
        int unsigned      r;
        ones  = '1;
        fills = {WIDTH{fill}};
        a     = 32'(amt);
        r     = a % WIDTH;
        case (mode)
            MODE_LSR: begin
                if (a >= WIDTH) res = fills;
                else            res = (d >> a) | (fills & ~(ones >> a));
            end
            // Arithmetic shift by >= WIDTH already yields all-sign.
            MODE_ASR: res = $signed(d) >>> a;
            MODE_LSL: begin
                if (a >= WIDTH) res = fills;
                else            res = (d << a) | (fills & ~(ones << a));
            end
            // r == 0 makes the complementary shift WIDTH, which yields zero.
            MODE_ROR: res = (d >> r) | (d << (WIDTH - r));
            MODE_ROL: res = (d << r) | (d >> (WIDTH - r));
            default:  res = d;
        endcase
        return res;
    endfunction

    always_comb begin
        step_live = shift_step(dout_q, mode_i, amt_i, fill_i);
        step_run  = shift_step(dout_q, mode_q, amt_q, fill_q);
        dout_d    = dout_q;
        if (load_i) begin
            dout_d = din_i;
        end else if (state_q == ST_RUN) begin
            dout_d = step_run;
        end else if (!start_i && shift_en_i) begin
            // start (even with cnt 0) owns the idle cycle over shift_en.
            dout_d = step_live;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= '0;
            amt_q    <= '0;
            fill_q   <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            dout_q   <= dout_d;
            done_q   <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
            parity_q <= ^dout_d;
`endif
            if (load_i) begin
                // Load aborts any burst silently.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            if (cnt_i != '0) begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                                cnt_q   <= cnt_i;
                                mode_q  <= mode_i;
                                amt_q   <= amt_i;
                                fill_q  <= fill_i;
                            end else begin
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout_o = dout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef SHIFT_REG_PARITY_EN
    assign parity_o = parity_q;
`endif

endmodule
